// File: rtl/mix_out_pkg.sv
// Shared types and defaults for the mixer output buffer (mix_out_buffer, sample_fifo).
package mix_out_pkg;

  localparam int unsigned SAMPLE_W            = 32;
  localparam int unsigned DEFAULT_DEPTH       = 8;
  localparam int unsigned DEFAULT_PRIME_LEVEL = 4;

  typedef enum logic {
    PRIME  = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Circular sample store for mix_out_buffer; level counter disambiguates full from empty.
module sample_fifo
  import mix_out_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned W     = SAMPLE_W,
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  // A push into a full FIFO is only legal when a pop frees a slot on the same edge.
  always_comb begin
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != LW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/mix_out_buffer.sv
// Primes a sample FIFO from the mixer, then streams it to the codec at most every other cycle.
// Optional feature: define MIX_OUT_ATTEN_EN to add the atten input (arithmetic right shift at pop).
module mix_out_buffer
  import mix_out_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned PRIME_LEVEL = DEFAULT_PRIME_LEVEL,
  localparam int unsigned LW         = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [SAMPLE_W-1:0] mix_down,
  input  logic                sample_tick,
  input  logic                audio_out_allowed,
`ifdef MIX_OUT_ATTEN_EN
  input  logic [2:0]          atten,
`endif
  input  logic                clear_flags,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_channel_audio_out,
  output logic [SAMPLE_W-1:0] right_channel_audio_out,
  output logic [LW-1:0]       level,
  output logic                overrun,
  output logic                underrun
);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                overrun_q, overrun_d;
  logic                underrun_q, underrun_d;
  logic                pop_c, push_c, ovr_set_c, und_set_c;
  logic [SAMPLE_W-1:0] head;
  logic [SAMPLE_W-1:0] head_scaled;
  logic [LW-1:0]       fifo_level;

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_c),
    .pop    (pop_c),
    .wdata  (mix_down),
    .head   (head),
    .level  (fifo_level)
  );

`ifdef MIX_OUT_ATTEN_EN
  assign head_scaled = SAMPLE_W'($signed(head) >>> atten);
`else
  assign head_scaled = head;
`endif

  // Next state, codec strobe and sticky flags.
  always_comb begin
    state_d    = state_q;
    write_d    = 1'b0;
    sample_d   = sample_q;
    und_set_c  = 1'b0;
    push_c     = sample_tick;
    pop_c      = (state_q == STREAM) && (fifo_level != '0) &&
                 audio_out_allowed && !write_q;
    ovr_set_c  = sample_tick && (fifo_level == LW'(DEPTH)) && !pop_c;

    if (state_q == PRIME) begin
      if (fifo_level >= LW'(PRIME_LEVEL)) state_d = STREAM;
    end else begin
      if ((fifo_level == '0) && audio_out_allowed) begin
        state_d   = PRIME;
        und_set_c = 1'b1;
      end
    end

    if (pop_c) begin
      write_d  = 1'b1;
      sample_d = head_scaled;
    end

    overrun_d  = clear_flags ? 1'b0 : (overrun_q  || ovr_set_c);
    underrun_d = clear_flags ? 1'b0 : (underrun_q || und_set_c);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= PRIME;
      write_q    <= 1'b0;
      sample_q   <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      sample_q   <= sample_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign write_audio_out         = write_q;
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;
  assign level                   = fifo_level;
  assign overrun                 = overrun_q;
  assign underrun                = underrun_q;

endmodule

// File: tb/tb_mix_out_buffer.sv
// Directed bench for mix_out_buffer (DEPTH=8, PRIME_LEVEL=4); atten case only with MIX_OUT_ATTEN_EN.
module tb_mix_out_buffer;
  import mix_out_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mix_down = '0;
  logic        sample_tick = 1'b0;
  logic        audio_out_allowed = 1'b0;
  logic        clear_flags = 1'b0;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic [3:0]  level;
  logic        overrun;
  logic        underrun;
`ifdef MIX_OUT_ATTEN_EN
  logic [2:0]  atten = '0;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  mix_out_buffer #(.DEPTH(8), .PRIME_LEVEL(4)) dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .mix_down                (mix_down),
    .sample_tick             (sample_tick),
    .audio_out_allowed       (audio_out_allowed),
`ifdef MIX_OUT_ATTEN_EN
    .atten                   (atten),
`endif
    .clear_flags             (clear_flags),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .level                   (level),
    .overrun                 (overrun),
    .underrun                (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    sample_tick = 1'b0;
    clear_flags = 1'b0;
    audio_out_allowed = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic push_ticks(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mix_down = base + 32'(i) * 32'h0100_0000;
      sample_tick = 1'b1;
      step();
    end
    sample_tick = 1'b0;
  endtask

  // Steps until a strobe (bounded); reports how many cycles it took.
  task automatic wait_strobe(input string tag, input logic [31:0] exp, output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (write_audio_out !== 1'b1 && waited < 10);
    check({tag, " strobe"}, 32'(write_audio_out), 32'd1);
    check({tag, " left"}, left_channel_audio_out, exp);
    check({tag, " right"}, right_channel_audio_out, exp);
  endtask

  task automatic count_strobes(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (write_audio_out === 1'b1) seen++;
    end
  endtask

  initial begin
    int gap;
    int seen;
    logic [31:0] drain [8];

    // Reset state
    resetn = 1'b0;
    #3;
    check("rst write", 32'(write_audio_out), 32'd0);
    check("rst left", left_channel_audio_out, 32'd0);
    check("rst level", 32'(level), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst underrun", 32'(underrun), 32'd0);
    check("rst state", 32'(dut.state_q), 32'(PRIME));
    do_reset();

    // Prime with four samples, then stream them out every other cycle
    audio_out_allowed = 1'b1;
    push_ticks(32'h1100_0000, 4);
    check("prime level", 32'(level), 32'd4);
    check("prime no write", 32'(write_audio_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_strobe("stream", 32'h1100_0000 + 32'(i) * 32'h0100_0000, gap);
      check("stream gap", 32'(gap), 32'd2);
    end
    step();
    check("drain write low", 32'(write_audio_out), 32'd0);
    check("drain level", 32'(level), 32'd0);
    check("drain underrun", 32'(underrun), 32'd1);
    check("drain state", 32'(dut.state_q), 32'(PRIME));
    check("drain hold", left_channel_audio_out, 32'h1400_0000);

    // clear_flags, then only three samples: stays primed
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("clear underrun", 32'(underrun), 32'd0);
    push_ticks(32'h3300_0000, 3);
    count_strobes(10, seen);
    check("below prime strobes", 32'(seen), 32'd0);
    check("below prime level", 32'(level), 32'd3);
    check("below prime state", 32'(dut.state_q), 32'(PRIME));

    // Nine samples with the codec blocked: ninth is dropped
    do_reset();
    push_ticks(32'h2100_0000, 9);
    check("full level", 32'(level), 32'd8);
    check("full overrun", 32'(overrun), 32'd1);
    check("full no write", 32'(write_audio_out), 32'd0);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("clear overrun", 32'(overrun), 32'd0);
    check("clear keeps level", 32'(level), 32'd8);

    // Tick coincident with a pop on a full FIFO is accepted
    audio_out_allowed = 1'b1;
    mix_down = 32'h2A00_0000;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("full pop write", 32'(write_audio_out), 32'd1);
    check("full pop data", left_channel_audio_out, 32'h2100_0000);
    check("full pop level", 32'(level), 32'd8);
    check("full pop overrun", 32'(overrun), 32'd0);
    drain = '{32'h2200_0000, 32'h2300_0000, 32'h2400_0000, 32'h2500_0000,
              32'h2600_0000, 32'h2700_0000, 32'h2800_0000, 32'h2A00_0000};
    for (int i = 0; i < 8; i++) begin
      wait_strobe("full drain", drain[i], gap);
      check("full drain gap", 32'(gap), 32'd2);
    end
    step();
    check("full drain level", 32'(level), 32'd0);
    check("full drain underrun", 32'(underrun), 32'd1);

    // Reset mid-stream with five queued samples
    do_reset();
    audio_out_allowed = 1'b1;
    push_ticks(32'h3100_0000, 6);
    check("mid write", 32'(write_audio_out), 32'd1);
    check("mid data", left_channel_audio_out, 32'h3100_0000);
    check("mid level", 32'(level), 32'd5);
    #2;
    resetn = 1'b0;
    #1;
    check("async write", 32'(write_audio_out), 32'd0);
    check("async left", left_channel_audio_out, 32'd0);
    check("async right", right_channel_audio_out, 32'd0);
    check("async level", 32'(level), 32'd0);
    step();
    resetn = 1'b1;
    count_strobes(6, seen);
    check("post rst strobes", 32'(seen), 32'd0);
    check("post rst level", 32'(level), 32'd0);
    push_ticks(32'h4100_0000, 4);
    wait_strobe("post rst first", 32'h4100_0000, gap);

`ifdef MIX_OUT_ATTEN_EN
    do_reset();
    atten = 3'd2;
    audio_out_allowed = 1'b1;
    push_ticks(32'h4000_0000, 4);
    wait_strobe("atten pos", 32'h1000_0000, gap);
    do_reset();
    audio_out_allowed = 1'b1;
    mix_down = 32'h8000_0000;
    sample_tick = 1'b1;
    step();
    push_ticks(32'h0100_0000, 3);
    wait_strobe("atten neg", 32'hE000_0000, gap);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mix_out_buffer.md
MIX_OUT_BUFFER -- requirements
Module: mix_out_buffer

Interface
REQ-001 Parameter: DEPTH, 8, FIFO entries (power of two, 4..64).
REQ-002 Parameter: PRIME_LEVEL, 4, samples required before streaming starts (1..DEPTH).
REQ-003 Port: clk  in  1  sole clock, all state on rising edge.
REQ-004 Port: resetn  in  1  asynchronous active-low reset.
REQ-005 Port: mix_down  in  32  mixed sample from the mixer stage.
REQ-006 Port: sample_tick  in  1  one-cycle strobe; mix_down valid, capture this cycle.
REQ-007 Port: audio_out_allowed  in  1  codec output FIFO has room.
REQ-008 Port: write_audio_out  out  1  one-cycle write strobe to codec.
REQ-009 Port: left_channel_audio_out  out  32  sample to codec, left.
REQ-010 Port: right_channel_audio_out  out  32  sample to codec, right (identical to left).
REQ-011 Port: level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 Port: overrun  out  1  sticky; a sample was dropped on full.
REQ-013 Port: underrun  out  1  sticky; FIFO emptied while streaming.
REQ-014 Port: clear_flags  in  1  synchronous clear of overrun and underrun.

Function
REQ-015 On sample_tick with level<DEPTH, mix_down SHALL be pushed at that edge; level increments next cycle.
REQ-016 On sample_tick with level==DEPTH and no pop that edge, sample SHALL be dropped, overrun set next cycle; with a simultaneous pop, sample is accepted.
REQ-017 Simultaneous push and pop SHALL leave level unchanged; FIFO order strictly preserved.
REQ-018 FSM states PRIME, STREAM; PRIME->STREAM when level>=PRIME_LEVEL; STREAM->PRIME when level==0 and audio_out_allowed==1 (underrun set same edge).
REQ-019 In STREAM, if level>0, audio_out_allowed==1 and write_audio_out==0 this cycle, next cycle write_audio_out=1, both channel outputs=FIFO head, head popped at that edge.
REQ-020 write_audio_out SHALL never be high two consecutive cycles; max one codec write per two clocks.
REQ-021 Channel outputs SHALL hold last written value between writes.
REQ-022 In PRIME, write_audio_out SHALL stay 0 regardless of audio_out_allowed.
REQ-023 clear_flags SHALL win over a same-cycle set of overrun/underrun.
REQ-024 Pointers wrap modulo DEPTH; level distinguishes full from empty.

Reset
REQ-025 resetn low SHALL immediately force: state PRIME, pointers 0, level 0, write_audio_out 0, channel outputs 0, overrun 0, underrun 0.
REQ-026 Reset mid-stream SHALL discard FIFO contents; no write strobe in the cycle resetn deasserts.

Configuration
REQ-027 Macro MIX_OUT_ATTEN_EN defined: extra input atten [2:0]; outputs SHALL equal head arithmetically right-shifted by atten (two's complement), applied at pop time.
REQ-028 MIX_OUT_ATTEN_EN undefined: no atten port; head passes unmodified.

Structure
REQ-029 Package mix_out_pkg SHALL hold state enum (PRIME, STREAM), SAMPLE_W=32, default DEPTH and PRIME_LEVEL constants.
REQ-030 Storage, pointers and level SHALL live in sub-module sample_fifo; FSM, flags and codec interface in mix_out_buffer.

Verification
REQ-031 Reset, 4 ticks of 0x11000000..0x14000000, audio_out_allowed=1 -> four strobes, outputs in order, spaced >=2 cycles, level returns 0, underrun=1, state PRIME.
REQ-032 9 ticks with audio_out_allowed=0 (DEPTH=8) -> level=8, overrun=1, 9th sample absent from later output.
REQ-033 3 ticks only, audio_out_allowed=1 -> no write_audio_out (below PRIME_LEVEL).
REQ-034 FIFO full, tick coincident with pop -> sample accepted, level stays 8, overrun stays 0.
REQ-035 resetn pulsed low mid-stream with level=5 -> outputs 0 asynchronously, level 0, no strobe after release until 4 new ticks.
REQ-036 MIX_OUT_ATTEN_EN, atten=2, sample 0x80000000 -> output 0xE0000000.
